dma_tsmap_reader: RTL
=====================

# dma_tsmap_reader

DMA-side initiator for the shared tag-map (tsmap) read port of the memory subsystem. It accepts capability-tag lookup requests from the DMA engine and converts each byte address into a tsmap word index. It issues the read on the DMA tsmap port and retries whenever the CPU wins the port. It then returns the single tag bit through a valid/ready response. A one-entry word cache avoids re-reading the same tsmap word on back-to-back lookups.

## Interface
- `HEAP_BASE`, 32'h2000_0000: byte base of the tag-covered region.
- `HEAP_SIZE`, 32'h0020_0000: covered region size in bytes. One tsmap bit covers 8 B; one 32-bit word covers 256 B; 8192 words.
- `clk_i`  in  1  clock.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  1  lookup request valid.
- `req_ready_o`  out  1  request accepted when both valid and ready are high.
- `req_addr_i`  in  32  byte address of the capability to check.
- `rsp_valid_o`  out  1  response valid; held until accepted.
- `rsp_ready_i`  in  1  response accepted.
- `rsp_tag_o`  out  1  tag bit.
- `rsp_err_o`  out  1  address outside [HEAP_BASE, HEAP_BASE+HEAP_SIZE).
- `inval_i`  in  1  invalidate the cached word (tsmap was written).
- `dma_tsmap_cs_o`  out  1  DMA tsmap read strobe.
- `dma_tsmap_addr_o`  out  16  tsmap word index; bits [15:13] are always 0.
- `tsmap_is_occupied_i`  in  1  CPU holds the port this cycle, so the DMA read is lost.
- `dma_tsmap_rdata_i`  in  32  DMA read data, valid the cycle after a won issue.
- `snooped_tsmap_cs_i`, `snooped_tsmap_addr_i[15:0]`, `snooped_tsmap_rdata_i[31:0]`  in: the CPU read issued in cycle N, presented in cycle N+1.
- `stall_cnt_o`  out  16  saturating count of lost issue cycles.

## Operation
- States:
  - IDLE: `req_ready_o`=1.
  - ISSUE
  - CAPTURE
  - RESP
- Index computation: `off = req_addr_i - HEAP_BASE` (32-bit); `word_idx = off[20:8]`; `bit_idx = off[7:3]`. Both are latched on accept.
- IDLE, on accept:
  - Out of range (`req_addr_i < HEAP_BASE` or `>= HEAP_BASE+HEAP_SIZE`): go to RESP with err=1, tag=0. No read is issued.
  - Cache hit (cache valid and tag == word_idx, inval_i low that cycle): go to RESP with tag = cache_data[bit_idx].
  - Otherwise: go to ISSUE.
- ISSUE:
  - `dma_tsmap_cs_o`=1 and `dma_tsmap_addr_o`=word_idx.
  - If `tsmap_is_occupied_i`=0: go to CAPTURE.
  - Else: stay in ISSUE (retry next cycle) and increment `stall_cnt_o` (saturates at 16'hFFFF).
- CAPTURE: latch `dma_tsmap_rdata_i` into the cache (valid=1, tag=word_idx) and into the response, then go to RESP.
- RESP: `rsp_valid_o`=1. Go to IDLE on `rsp_ready_i`.
- `inval_i`:
  - Clears the cache valid bit in any state.
  - If it coincides with CAPTURE, inval wins: the cache stays invalid, but the response still uses the fetched data.
- The response outputs are stable while `rsp_valid_o`=1 and `rsp_ready_i`=0.

## Timing
- Reset values: `req_ready_o`=0 during reset and 1 after. `rsp_valid_o`, `rsp_tag_o`, `rsp_err_o`, `dma_tsmap_cs_o`, `dma_tsmap_addr_o` and `stall_cnt_o` are all 0. Cache invalid. State IDLE.
- Assertion of `rstn_i` mid-operation aborts immediately: `dma_tsmap_cs_o` drops asynchronously and any in-flight lookup is discarded.
- Latencies from accept to `rsp_valid_o`:
  - Hit or out of range: 1 cycle.
  - Uncontended miss: 3 cycles (ISSUE, CAPTURE, RESP).
  - Contended miss: add 1 cycle per lost ISSUE cycle.
- `tsmap_is_occupied_i` is sampled in the same cycle as `dma_tsmap_cs_o`. A won issue has its data on the next cycle only.
- Back-to-back: a new request can be accepted the cycle after the RESP handshake, because `req_ready_o` is high only in IDLE.

## Configuration
- `DMA_TSMAP_SNOOP_EN` defined:
  - In ISSUE, if the previous cycle was a lost issue and `snooped_tsmap_cs_i`=1 with `snooped_tsmap_addr_i`==word_idx, take `snooped_tsmap_rdata_i` as the read data.
  - In that cycle, `dma_tsmap_cs_o` is forced to 0, the cache is filled, and the state goes directly to RESP. The lost-issue cycle is still counted in `stall_cnt_o`.
  - Contended-miss latency then becomes 3 cycles, same as uncontended.
- Undefined: the snoop inputs are ignored, and lost issues always retry.

## Structure
- Package `dma_tsmap_pkg`:
  - State enum `tsmap_rd_state_e`.
  - Localparams `TSMAP_WORD_W`=13, `TSMAP_BIT_W`=5, `TSMAP_GRAN_LOG2`=3.
  - Cache entry struct `{valid, tag[12:0], data[31:0]}`.
- One sub-module, `dma_tsmap_word_cache`: the single-entry cache with lookup, fill and invalidate. The FSM and the stall counter stay in the top level.

## Test plan
- Request 0x2000_0108 with word 1 = 32'h0000_0002, no contention:
  - Read issued with addr=1, CAPTURE, then tag=1 (bit 1) three cycles after accept.
  - An immediate follow-up request 0x2000_0100 is a hit: tag=0 after 1 cycle, with no `dma_tsmap_cs_o`.
- Request 0x1FFF_FFF8 and request 0x2020_0000: each gives err=1, tag=0 after 1 cycle, and `dma_tsmap_cs_o` never asserts.
- `tsmap_is_occupied_i` held high for 4 issue cycles (snoop off):
  - 4 retries; `stall_cnt_o`=4; response 7 cycles after accept.
- `DMA_TSMAP_SNOOP_EN` on, CPU reads the same word index during the lost cycle:
  - Response uses the snooped data 3 cycles after accept.
  - Second issue suppressed; `stall_cnt_o`=1.
- `inval_i` during CAPTURE, then the same word requested again: the second lookup issues a fresh read, with no hit.
- `rstn_i` low for 1 cycle while in ISSUE: `dma_tsmap_cs_o` drops immediately, all outputs return to reset values, cache invalid, and the next request behaves as a cold miss.

Source files
------------

// File: rtl/dma_tsmap_pkg.sv
// rtl/dma_tsmap_pkg.sv - shared types and constants for the DMA tag-map reader
//
// Purpose: read FSM state encoding, tsmap geometry constants and the word
// cache entry layout used by dma_tsmap_reader and dma_tsmap_word_cache.
// Ports: none (package).
package dma_tsmap_pkg;

    // One tsmap word covers 2^(GRAN+BIT) bytes; WORD_W bits index the words.
    localparam int TSMAP_WORD_W    = 13;
    localparam int TSMAP_BIT_W     = 5;
    localparam int TSMAP_GRAN_LOG2 = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } tsmap_rd_state_e;

    typedef struct packed {
        logic                    valid;
        logic [TSMAP_WORD_W-1:0] tag;
        logic [31:0]             data;
    } tsmap_cache_entry_t;

endpackage

// File: rtl/dma_tsmap_word_cache.sv
// rtl/dma_tsmap_word_cache.sv - single-entry tsmap word cache
//
// Purpose: remembers the last tsmap word fetched by the reader so that
// back-to-back lookups in the same 256 B block skip the shared read port.
// Ports:
//   clk_i, rstn_i      clock, asynchronous active-low reset
//   lookup_idx_i       word index being looked up this cycle
//   hit_o, data_o      lookup result; a hit is suppressed while inval_i is high
//   fill_i             write fill_idx_i/fill_data_i into the entry
//   inval_i            clear the valid bit; wins over a simultaneous fill
module dma_tsmap_word_cache
    import dma_tsmap_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic [TSMAP_WORD_W-1:0] lookup_idx_i,
    output logic                    hit_o,
    output logic [31:0]             data_o,
    input  logic                    fill_i,
    input  logic [TSMAP_WORD_W-1:0] fill_idx_i,
    input  logic [31:0]             fill_data_i,
    input  logic                    inval_i
);

    tsmap_cache_entry_t entry_q;
    tsmap_cache_entry_t entry_d;

    always_comb begin
        entry_d = entry_q;
        if (fill_i) begin
            entry_d.valid = 1'b1;
            entry_d.tag   = fill_idx_i;
            entry_d.data  = fill_data_i;
        end
        // A tsmap write racing the fill means the fetched word may be stale.
        if (inval_i) begin
            entry_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign hit_o  = entry_q.valid && (entry_q.tag == lookup_idx_i) && !inval_i;
    assign data_o = entry_q.data;

endmodule

// File: rtl/dma_tsmap_reader.sv
// rtl/dma_tsmap_reader.sv - DMA-side capability-tag lookup through the shared tsmap port
//
// Purpose: converts a byte address into a tsmap word/bit index, reads the word
// on the DMA tsmap port (retrying while the CPU owns the port) and returns the
// tag bit over a valid/ready response. A one-word cache serves repeat lookups.
// Optional feature macro: DMA_TSMAP_SNOOP_EN (reuse a CPU read of the same
// word observed right after a lost issue instead of retrying).
// Ports:
//   clk_i, rstn_i                 clock, asynchronous active-low reset
//   req_valid_i/req_ready_o/req_addr_i          lookup request
//   rsp_valid_o/rsp_ready_i/rsp_tag_o/rsp_err_o response (err = out of heap)
//   inval_i                       tsmap was written; drop the cached word
//   dma_tsmap_cs_o/addr_o/rdata_i DMA read port (data one cycle after a win)
//   tsmap_is_occupied_i           CPU owns the port; this cycle's DMA read is lost
//   snooped_tsmap_cs_i/addr_i/rdata_i  CPU read of cycle N, seen in cycle N+1
//   stall_cnt_o                   saturating count of lost issue cycles
module dma_tsmap_reader
    import dma_tsmap_pkg::*;
#(
    parameter logic [31:0] HEAP_BASE = 32'h2000_0000,
    parameter logic [31:0] HEAP_SIZE = 32'h0020_0000
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_tag_o,
    output logic        rsp_err_o,
    input  logic        inval_i,
    output logic        dma_tsmap_cs_o,
    output logic [15:0] dma_tsmap_addr_o,
    input  logic        tsmap_is_occupied_i,
    input  logic [31:0] dma_tsmap_rdata_i,
    input  logic        snooped_tsmap_cs_i,
    input  logic [15:0] snooped_tsmap_addr_i,
    input  logic [31:0] snooped_tsmap_rdata_i,
    output logic [15:0] stall_cnt_o
);

    localparam logic [31:0] HEAP_END = HEAP_BASE + HEAP_SIZE;
    localparam int          IDX_LSB  = TSMAP_GRAN_LOG2 + TSMAP_BIT_W;
    localparam int          IDX_MSB  = IDX_LSB + TSMAP_WORD_W - 1;

    tsmap_rd_state_e         state_q, state_d;
    logic [TSMAP_WORD_W-1:0] word_idx_q, word_idx_d;
    logic [TSMAP_BIT_W-1:0]  bit_idx_q, bit_idx_d;
    logic                    rsp_tag_q, rsp_tag_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [15:0]             stall_cnt_q, stall_cnt_d;

    logic [31:0]             off;
    logic                    in_range;
    logic [TSMAP_WORD_W-1:0] req_word_idx;
    logic [TSMAP_BIT_W-1:0]  req_bit_idx;
    logic                    accept;
    logic                    cache_hit;
    logic [31:0]             cache_data;
    logic                    cache_fill;
    logic [31:0]             fill_data;
    logic                    issue_cs;
    logic                    snoop_take;
    logic [31:0]             snoop_data;

    assign off          = req_addr_i - HEAP_BASE;
    assign in_range     = (req_addr_i >= HEAP_BASE) && (req_addr_i < HEAP_END);
    assign req_word_idx = off[IDX_MSB:IDX_LSB];
    assign req_bit_idx  = off[IDX_LSB-1:TSMAP_GRAN_LOG2];

    // Address bits above the heap span and below the tag granule carry no index.
    logic unused_off;
    assign unused_off = ^{off[31:IDX_MSB+1], off[TSMAP_GRAN_LOG2-1:0]};

    // Ready is forced low while reset is asserted, not just after the first edge.
    assign req_ready_o = rstn_i && (state_q == ST_IDLE);
    assign accept      = req_valid_i && req_ready_o;

`ifdef DMA_TSMAP_SNOOP_EN
    logic lost_q, lost_d;

    // The CPU read of the previous (lost) cycle is visible now; if it hit our
    // word its data is as good as the one we were about to re-request.
    assign snoop_take = (state_q == ST_ISSUE) && lost_q && snooped_tsmap_cs_i &&
                        (snooped_tsmap_addr_i == {{(16-TSMAP_WORD_W){1'b0}}, word_idx_q});
    assign snoop_data = snooped_tsmap_rdata_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            lost_q <= 1'b0;
        end else begin
            lost_q <= lost_d;
        end
    end
`else
    assign snoop_take = 1'b0;
    assign snoop_data = '0;

    logic unused_snoop;
    assign unused_snoop = ^{snooped_tsmap_cs_i, snooped_tsmap_addr_i, snooped_tsmap_rdata_i};
`endif

    dma_tsmap_word_cache u_cache (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .lookup_idx_i (req_word_idx),
        .hit_o        (cache_hit),
        .data_o       (cache_data),
        .fill_i       (cache_fill),
        .fill_idx_i   (word_idx_q),
        .fill_data_i  (fill_data),
        .inval_i      (inval_i)
    );

    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        bit_idx_d   = bit_idx_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_err_d   = rsp_err_q;
        stall_cnt_d = stall_cnt_q;
        cache_fill  = 1'b0;
        fill_data   = dma_tsmap_rdata_i;
        issue_cs    = 1'b0;
`ifdef DMA_TSMAP_SNOOP_EN
        lost_d      = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    word_idx_d = req_word_idx;
                    bit_idx_d  = req_bit_idx;
                    rsp_tag_d  = 1'b0;
                    rsp_err_d  = 1'b0;
                    if (!in_range) begin
                        rsp_err_d = 1'b1;
                        state_d   = ST_RESP;
                    end else if (cache_hit) begin
                        rsp_tag_d = cache_data[req_bit_idx];
                        state_d   = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                if (snoop_take) begin
                    cache_fill = 1'b1;
                    fill_data  = snoop_data;
                    rsp_tag_d  = snoop_data[bit_idx_q];
                    state_d    = ST_RESP;
                end else begin
                    issue_cs = 1'b1;
                    if (!tsmap_is_occupied_i) begin
                        state_d = ST_CAPTURE;
                    end else begin
`ifdef DMA_TSMAP_SNOOP_EN
                        lost_d = 1'b1;
`endif
                        if (stall_cnt_q != 16'hFFFF) begin
                            stall_cnt_d = stall_cnt_q + 16'd1;
                        end
                    end
                end
            end

            ST_CAPTURE: begin
                cache_fill = 1'b1;
                rsp_tag_d  = dma_tsmap_rdata_i[bit_idx_q];
                state_d    = ST_RESP;
            end

            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            word_idx_q  <= '0;
            bit_idx_q   <= '0;
            rsp_tag_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            word_idx_q  <= word_idx_d;
            bit_idx_q   <= bit_idx_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_err_q   <= rsp_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Strobe decodes straight from the state register so reset drops it at once.
    assign dma_tsmap_cs_o   = issue_cs;
    assign dma_tsmap_addr_o = issue_cs ? {{(16-TSMAP_WORD_W){1'b0}}, word_idx_q} : 16'd0;
    assign rsp_valid_o      = (state_q == ST_RESP);
    assign rsp_tag_o        = rsp_tag_q;
    assign rsp_err_o        = rsp_err_q;
    assign stall_cnt_o      = stall_cnt_q;

endmodule
